// File: rtl/vie_mem_stage.sv
// vie memory stage: merges execute results with SRAM load data into the writeback bus.
// Optional VIE_MS_FWD_EN adds the ms_fwd_o forwarding port for issue.
module vie_mem_stage #(
  parameter int RSBUS_W = 73,
  parameter int WBBUS_W = 72
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [RSBUS_W-1:0] rsbus_i,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allowin,
  output logic               ms_allowin,
  output logic [WBBUS_W-1:0] wbbus_o
`ifdef VIE_MS_FWD_EN
  ,
  output logic [39:0]        ms_fwd_o
`endif
);

  logic        ms_valid_r;
  logic        is_load_r;
  logic [6:0]  dest_r;
  logic [31:0] fixres_r;
  logic [31:0] pc_r;
  logic        first_r;
  logic [31:0] rdbuf_r;
  logic        rdbuf_v_r;

  logic        ms_cango;
  logic        rs_valid;
  logic        leave;
  logic        capture;
  logic [31:0] load_value;
  logic [31:0] result;

  assign ms_cango   = 1'b1;
  assign rs_valid   = rsbus_i[72];
  assign ms_allowin = !ms_valid_r || (ms_cango && ws_allowin);
  assign leave      = ms_valid_r && ws_allowin;
  assign capture    = ms_valid_r && is_load_r && first_r && !ws_allowin;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ms_valid_r <= 1'b0;
      is_load_r  <= 1'b0;
      dest_r     <= 7'd0;
      fixres_r   <= 32'd0;
      pc_r       <= 32'd0;
      first_r    <= 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid_r <= rs_valid;
        if (rs_valid) begin
          is_load_r <= rsbus_i[71];
          dest_r    <= rsbus_i[70:64];
          fixres_r  <= rsbus_i[63:32];
          pc_r      <= rsbus_i[31:0];
        end
      end
      first_r <= ms_allowin && rs_valid;
    end
  end

  // SRAM data is only valid in the first MS cycle; keep it if ws stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdbuf_r   <= 32'd0;
      rdbuf_v_r <= 1'b0;
    end else if (leave) begin
      rdbuf_v_r <= 1'b0;
    end else if (capture) begin
      rdbuf_r   <= data_sram_rdata;
      rdbuf_v_r <= 1'b1;
    end
  end

  assign load_value = rdbuf_v_r ? rdbuf_r : data_sram_rdata;
  assign result     = is_load_r ? load_value : fixres_r;

  assign wbbus_o = {ms_valid_r && ms_cango, dest_r, result, pc_r};

`ifdef VIE_MS_FWD_EN
  assign ms_fwd_o = {ms_valid_r, dest_r, result};
`endif

endmodule

// File: tb/tb_vie_mem_stage.sv
// Bench for vie_mem_stage: directed scenarios plus random traffic
// checked against a per-entry model of the stage.
module tb_vie_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [72:0] rsbus_i = '0;
  logic [31:0] data_sram_rdata = '0;
  logic        ws_allowin = 1'b0;
  logic        ms_allowin;
  logic [71:0] wbbus_o;
`ifdef VIE_MS_FWD_EN
  logic [39:0] ms_fwd_o;
`endif

  vie_mem_stage dut (
    .clock           (clock),
    .reset           (reset),
    .rsbus_i         (rsbus_i),
    .data_sram_rdata (data_sram_rdata),
    .ws_allowin      (ws_allowin),
    .ms_allowin      (ms_allowin),
    .wbbus_o         (wbbus_o)
`ifdef VIE_MS_FWD_EN
    ,
    .ms_fwd_o        (ms_fwd_o)
`endif
  );

  always #5 clock = ~clock;

  int ntot = 0;
  int nfail = 0;

  // Model: the entry held in MS, how long it has been there, and the
  // SRAM word seen in its first cycle.
  logic        m_valid = 0, m_load = 0;
  logic [6:0]  m_dest = 0;
  logic [31:0] m_fix = 0, m_pc = 0, m_first = 0;
  int          m_age = 0;
  logic        n_valid, n_load;
  logic [6:0]  n_dest;
  logic [31:0] n_fix, n_pc, n_first;
  int          n_age;
  bit          pending = 0;

  function automatic logic [72:0] mk(input bit v, input bit ld,
                                     input logic [6:0] d,
                                     input logic [31:0] f,
                                     input logic [31:0] p);
    return {v, ld, d, f, p};
  endfunction

  function logic [31:0] m_res();
    if (!m_load) return m_fix;
    return (m_age == 0) ? data_sram_rdata : m_first;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs,
                     input logic [71:0] exp);
    ntot++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [72:0] rs, input logic [31:0] rd,
                       input logic ws);
    if (pending) begin
      @(posedge clock);
      m_valid = n_valid; m_load = n_load; m_dest = n_dest;
      m_fix = n_fix; m_pc = n_pc; m_first = n_first; m_age = n_age;
    end
    @(negedge clock);
    rsbus_i = rs;
    data_sram_rdata = rd;
    ws_allowin = ws;
    #1;
    chk("allowin", 72'(ms_allowin), 72'(!m_valid || ws));
    if (m_valid)
      chk("wbbus", wbbus_o, {1'b1, m_dest, m_res(), m_pc});
    else
      chk("wb_idle", {71'd0, wbbus_o[71] | 1'($isunknown(wbbus_o))}, 72'd0);
`ifdef VIE_MS_FWD_EN
    if (m_valid)
      chk("fwd", 72'(ms_fwd_o), 72'({1'b1, m_dest, m_res()}));
    else
      chk("fwd_idle", 72'(ms_fwd_o[39]), 72'd0);
`endif
    n_valid = m_valid; n_load = m_load; n_dest = m_dest;
    n_fix = m_fix; n_pc = m_pc; n_first = m_first; n_age = m_age + 1;
    if (m_valid && m_age == 0) n_first = rd;
    if (!m_valid || ws) begin
      n_valid = rs[72];
      if (rs[72]) begin
        n_load = rs[71]; n_dest = rs[70:64];
        n_fix = rs[63:32]; n_pc = rs[31:0]; n_age = 0;
      end
    end
    pending = 1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_allowin", 72'(ms_allowin), 72'd1);
    chk("rst_wbbus", wbbus_o, 72'd0);
`ifdef VIE_MS_FWD_EN
    chk("rst_fwd", 72'(ms_fwd_o), 72'd0);
`endif
    m_valid = 0; m_load = 0; m_dest = 0; m_fix = 0;
    m_pc = 0; m_first = 0; m_age = 0; pending = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  logic [72:0] bub;

  initial begin
    bub = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("init_allowin", 72'(ms_allowin), 72'd1);
    chk("init_wbbus", wbbus_o, 72'd0);

    // ALU pass-through
    drive(mk(1, 0, 7'd5, 32'h1234_5678, 32'hBFC0_0010), 32'h0, 1);
    drive(bub, 32'h0, 1);
    chk("alu", wbbus_o, {1'b1, 7'd5, 32'h1234_5678, 32'hBFC0_0010});

    // load without stall
    drive(mk(1, 1, 7'd3, 32'h0, 32'hBFC0_0020), 32'h0, 1);
    drive(bub, 32'hDEAD_BEEF, 1);
    chk("load_nostall", 72'(wbbus_o[63:32]), 72'(32'hDEAD_BEEF));

    // load with 3-cycle stall
    drive(mk(1, 1, 7'd9, 32'h5555_5555, 32'hBFC0_0030), 32'h0, 1);
    drive(bub, 32'hCAFE_0001, 0);
    chk("stall_res0", 72'(wbbus_o[63:32]), 72'(32'hCAFE_0001));
    chk("stall_allow0", 72'(ms_allowin), 72'd0);
`ifdef VIE_MS_FWD_EN
    chk("stall_fwd0", 72'(ms_fwd_o), 72'({1'b1, 7'd9, 32'hCAFE_0001}));
`endif
    drive(bub, 32'h0, 0);
    chk("stall_res1", 72'(wbbus_o[63:32]), 72'(32'hCAFE_0001));
    chk("stall_allow1", 72'(ms_allowin), 72'd0);
`ifdef VIE_MS_FWD_EN
    chk("stall_fwd1", 72'(ms_fwd_o), 72'({1'b1, 7'd9, 32'hCAFE_0001}));
`endif
    drive(bub, 32'hFFFF_FFFF, 0);
    chk("stall_res2", 72'(wbbus_o[63:32]), 72'(32'hCAFE_0001));
`ifdef VIE_MS_FWD_EN
    chk("stall_fwd2", 72'(ms_fwd_o), 72'({1'b1, 7'd9, 32'hCAFE_0001}));
`endif
    drive(bub, 32'h0BAD_0BAD, 1);
    chk("release", wbbus_o, {1'b1, 7'd9, 32'hCAFE_0001, 32'hBFC0_0030});
    drive(mk(1, 1, 7'd4, 32'h0, 32'hBFC0_0040), 32'h0, 1);
    chk("retired", 72'(wbbus_o[71]), 72'd0);
    drive(bub, 32'h0000_ABCD, 1);
    chk("buf_cleared", 72'(wbbus_o[63:32]), 72'(32'h0000_ABCD));

    // back-to-back load, ALU, load (dest 0 on the last)
    drive(mk(1, 1, 7'd1, 32'h0, 32'h100), 32'h0, 1);
    drive(mk(1, 0, 7'd2, 32'h7777_0000, 32'h104), 32'h1111_1111, 1);
    chk("b2b_load1", wbbus_o, {1'b1, 7'd1, 32'h1111_1111, 32'h100});
    drive(mk(1, 1, 7'd0, 32'h0, 32'h108), 32'h2222_2222, 1);
    chk("b2b_alu", wbbus_o, {1'b1, 7'd2, 32'h7777_0000, 32'h104});
    drive(bub, 32'h3333_3333, 1);
    chk("b2b_load2", wbbus_o, {1'b1, 7'd0, 32'h3333_3333, 32'h108});

    // reset in the middle of a load stall
    drive(mk(1, 1, 7'd6, 32'h0, 32'h200), 32'h0, 1);
    drive(bub, 32'h4444_4444, 0);
    drive(bub, 32'h0, 0);
    do_reset();
    drive(mk(1, 1, 7'd7, 32'h0, 32'h204), 32'h0, 1);
    drive(bub, 32'h5A5A_5A5A, 0);
    chk("post_rst_load", 72'(wbbus_o[63:32]), 72'(32'h5A5A_5A5A));
    drive(bub, 32'h0, 0);
    chk("post_rst_hold", 72'(wbbus_o[63:32]), 72'(32'h5A5A_5A5A));

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(mk($urandom_range(3) != 0, 1'($urandom), 7'($urandom),
               $urandom, $urandom),
            $urandom, $urandom_range(4) > 1);
    end
    drive(bub, 32'h0, 1);

    $display("%0d/%0d checks passed", ntot - nfail, ntot);
    $finish;
  end

endmodule
